// File: rtl/bp_common_pkg.sv
// Shared types and constants for the local register responder slice.
// Processor configuration enum, FSM state and access size encodings,
// and the default local register window base.
package bp_common_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0,
      e_bp_inv_cfg     = 2'd1,
      e_bp_unicore_cfg = 2'd2
   } bp_params_e;

   typedef enum logic [0:0] {
      e_idle = 1'b0,
      e_resp = 1'b1
   } bp_lrr_state_e;

   typedef enum logic [1:0] {
      e_size_1B = 2'd0,
      e_size_2B = 2'd1,
      e_size_4B = 2'd2,
      e_size_8B = 2'd3
   } bp_lrr_size_e;

   // Byte address of local register 0; sits well below the DRAM base.
   localparam logic [39:0] local_reg_base_gp = 40'h00_0010_0000;

   // Physical address width per configuration; every configuration in this
   // slice shares the 40-bit physical address space.
   function automatic int bp_paddr_width(input bp_params_e cfg);
      int width;
      case (cfg)
         e_bp_default_cfg: width = 40;
         e_bp_inv_cfg:     width = 40;
         e_bp_unicore_cfg: width = 40;
         default:          width = 40;
      endcase
      return width;
   endfunction

endpackage

// File: rtl/bp_lrr_lane_align.sv
// Byte-lane alignment for the local register responder.
// Converts an access size and an in-word byte offset into a byte-enable mask,
// shifts store data onto its lanes and extracts right-aligned load data.
module bp_lrr_lane_align
   import bp_common_pkg::*;
(
   input  bp_lrr_size_e size,
   input  logic [2:0]   offset,
   input  logic [63:0]  store_data,
   input  logic [63:0]  reg_data,
   output logic [7:0]   byte_mask,
   output logic [63:0]  store_shifted,
   output logic [63:0]  load_data
);

   logic [7:0]  lane_bytes_s;
   logic [63:0] size_mask_s;
   logic [5:0]  bit_shift_s;

   assign bit_shift_s = {offset, 3'b000};

   // Size decode to lane count / data mask, then shift onto the addressed lanes.
   always_comb begin
      lane_bytes_s = 8'h01;
      size_mask_s  = 64'h0000_0000_0000_00FF;
      case (size)
         e_size_1B: begin
            lane_bytes_s = 8'h01;
            size_mask_s  = 64'h0000_0000_0000_00FF;
         end
         e_size_2B: begin
            lane_bytes_s = 8'h03;
            size_mask_s  = 64'h0000_0000_0000_FFFF;
         end
         e_size_4B: begin
            lane_bytes_s = 8'h0F;
            size_mask_s  = 64'h0000_0000_FFFF_FFFF;
         end
         e_size_8B: begin
            lane_bytes_s = 8'hFF;
            size_mask_s  = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         default: begin
            lane_bytes_s = 8'h01;
            size_mask_s  = 64'h0000_0000_0000_00FF;
         end
      endcase
      byte_mask     = lane_bytes_s << offset;
      store_shifted = store_data << bit_shift_s;
      load_data     = (reg_data >> bit_shift_s) & size_mask_s;
   end

endmodule

// File: rtl/bp_local_reg_responder.sv
// Uncached local register responder: reg_els_p 64-bit registers at
// base_addr_p + 8*i, one outstanding command, access performed on the accept
// edge and the response held until consumed.
// Optional macro BP_LOCAL_REG_RESP_ERR_EN: unmapped or misaligned commands
// return resp_err_o=1 with no side effects. Without it, errors are never
// reported, misaligned addresses are truncated to size alignment, unmapped
// loads return 0 and unmapped stores are dropped.
module bp_local_reg_responder
   import bp_common_pkg::*;
#(
   parameter bp_params_e  bp_params_p   = e_bp_inv_cfg,
   parameter int          reg_els_p     = 8,
   parameter logic [39:0] base_addr_p   = local_reg_base_gp,
   localparam int         paddr_width_p = bp_paddr_width(bp_params_p)
)
(
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     cmd_v_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_w_i,
   input  logic [paddr_width_p-1:0] cmd_addr_i,
   input  logic [1:0]               cmd_size_i,
   input  logic [63:0]              cmd_data_i,
   output logic                     resp_v_o,
   input  logic                     resp_yumi_i,
   output logic                     resp_w_o,
   output logic [63:0]              resp_data_o,
   output logic                     resp_err_o
);

   localparam int lg_els_lp = $clog2(reg_els_p);

   bp_lrr_state_e state_r, state_next_s;
   logic [63:0]   regs_r [reg_els_p];

   logic          cmd_ready_r, resp_v_r, resp_w_r, resp_err_r;
   logic [63:0]   resp_data_r;

   logic          accept_s, yumi_s, mapped_s, err_s, access_ok_s;
   logic [63:0]   addr_ext_s, offset_s, limit_s;
   logic [2:0]    size_low_mask_s, word_off_s;
   logic [lg_els_lp-1:0] idx_s;
   logic [7:0]    byte_mask_s;
   logic [63:0]   store_shifted_s, load_data_s;

   // Handshakes: cmd_ready_r is only high in e_idle, so accept needs no state term.
   assign accept_s = cmd_v_i & cmd_ready_r;
   assign yumi_s   = resp_yumi_i & (state_r == e_resp);

   // Address decode against the register window (computed in 64 bits so the
   // window end can never wrap).
   assign addr_ext_s      = 64'(cmd_addr_i);
   assign offset_s        = addr_ext_s - 64'(base_addr_p);
   assign limit_s         = 64'(reg_els_p) << 3;
   assign mapped_s        = (addr_ext_s >= 64'(base_addr_p)) && (offset_s < limit_s);
   assign idx_s           = offset_s[3 +: lg_els_lp];
   assign size_low_mask_s = 3'((4'd1 << cmd_size_i) - 4'd1);
   // Aligned accesses are unchanged; misaligned ones drop the low bits
   // (only reachable as an access when errors are disabled).
   assign word_off_s      = cmd_addr_i[2:0] & ~size_low_mask_s;

`ifdef BP_LOCAL_REG_RESP_ERR_EN
   logic aligned_s;
   assign aligned_s = (cmd_addr_i[2:0] & size_low_mask_s) == 3'd0;
   assign err_s     = ~(mapped_s & aligned_s);
`else
   assign err_s     = 1'b0;
`endif

   assign access_ok_s = mapped_s & ~err_s;

   bp_lrr_lane_align lane_align (
      .size          (bp_lrr_size_e'(cmd_size_i)),
      .offset        (word_off_s),
      .store_data    (cmd_data_i),
      .reg_data      (regs_r[idx_s]),
      .byte_mask     (byte_mask_s),
      .store_shifted (store_shifted_s),
      .load_data     (load_data_s)
   );

   // Next-state logic of the two-state accept/respond FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         e_idle: begin
            if (accept_s) state_next_s = e_resp;
            else          state_next_s = e_idle;
         end
         e_resp: begin
            if (yumi_s) state_next_s = e_idle;
            else        state_next_s = e_resp;
         end
         default: state_next_s = e_idle;
      endcase
   end

   // FSM state plus registered handshake and response outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= e_idle;
         cmd_ready_r <= 1'b0;
         resp_v_r    <= 1'b0;
         resp_w_r    <= 1'b0;
         resp_err_r  <= 1'b0;
         resp_data_r <= 64'd0;
      end else begin
         state_r     <= state_next_s;
         cmd_ready_r <= (state_next_s == e_idle);
         resp_v_r    <= (state_next_s == e_resp);
         if (accept_s) begin
            resp_w_r    <= cmd_w_i;
            resp_err_r  <= err_s;
            resp_data_r <= (!cmd_w_i && access_ok_s) ? load_data_s : 64'd0;
         end
      end
   end

   // Register file: byte-lane store committed on the accept edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < reg_els_p; i++) regs_r[i] <= 64'd0;
      end else if (accept_s && cmd_w_i && access_ok_s) begin
         for (int b = 0; b < 8; b++) begin
            if (byte_mask_s[b]) regs_r[idx_s][8*b +: 8] <= store_shifted_s[8*b +: 8];
         end
      end
   end

   assign cmd_ready_o = cmd_ready_r;
   assign resp_v_o    = resp_v_r;
   assign resp_w_o    = resp_w_r;
   assign resp_data_o = resp_data_r;
   assign resp_err_o  = resp_err_r;

endmodule

// File: tb/tb_bp_local_reg_responder.sv
// Self-checking bench for bp_local_reg_responder: directed vector table,
// hand-written handshake/reset sequences and randomized commands checked
// against a byte-addressed reference model.
module tb_bp_local_reg_responder;
   import bp_common_pkg::*;

   localparam int          REG_ELS = 8;
   localparam logic [39:0] BASE    = 40'h00_0010_0000;
`ifdef BP_LOCAL_REG_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_v = 1'b0, cmd_w = 1'b0, resp_yumi = 1'b0;
   logic [39:0] cmd_addr = 40'd0;
   logic [1:0]  cmd_size = 2'd0;
   logic [63:0] cmd_data = 64'd0;
   logic        cmd_ready_o, resp_v_o, resp_w_o, resp_err_o;
   logic [63:0] resp_data_o;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [8*REG_ELS];

   always #5 clk = ~clk;

   bp_local_reg_responder #(
      .bp_params_p (e_bp_inv_cfg),
      .reg_els_p   (REG_ELS),
      .base_addr_p (BASE)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .cmd_v_i     (cmd_v),
      .cmd_ready_o (cmd_ready_o),
      .cmd_w_i     (cmd_w),
      .cmd_addr_i  (cmd_addr),
      .cmd_size_i  (cmd_size),
      .cmd_data_i  (cmd_data),
      .resp_v_o    (resp_v_o),
      .resp_yumi_i (resp_yumi),
      .resp_w_o    (resp_w_o),
      .resp_data_o (resp_data_o),
      .resp_err_o  (resp_err_o)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: the window as a flat byte array.
   function automatic void model_access(input logic w, input logic [39:0] addr, input logic [1:0] size,
                                        input logic [63:0] data, output logic [63:0] rdata, output logic err);
      int nbytes;
      logic mapped, aligned;
      logic [39:0] a;
      nbytes  = 1 << size;
      mapped  = (addr >= BASE) && (addr < BASE + 40'(8*REG_ELS));
      aligned = (addr % nbytes) == 0;
      rdata   = 64'd0;
      err     = ERR_EN && !(mapped && aligned);
      if (err || !mapped) return;
      a = addr - (addr % nbytes) - BASE;
      for (int k = 0; k < nbytes; k++) begin
         if (w) mem[int'(a) + k] = data[8*k +: 8];
         else   rdata[8*k +: 8] = mem[int'(a) + k];
      end
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 8*REG_ELS; i++) mem[i] = 8'd0;
   endtask

   // One command through the full handshake; called at a negedge.
   task automatic run_cmd(input string nm, input logic w, input logic [39:0] addr, input logic [1:0] size,
                          input logic [63:0] data, input int hold, input logic [63:0] exp_data, input logic exp_err);
      int n = 0;
      while (cmd_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check({nm, "_ready_timeout"}, {63'd0, cmd_ready_o}, 64'd1);
      cmd_v = 1'b1; cmd_w = w; cmd_addr = addr; cmd_size = size; cmd_data = data;
      @(negedge clk);
      cmd_v = 1'b0;
      check({nm, "_resp_v"}, {63'd0, resp_v_o}, 64'd1);
      check({nm, "_data"}, resp_data_o, exp_data);
      check({nm, "_err"}, {63'd0, resp_err_o}, {63'd0, exp_err});
      check({nm, "_w"}, {63'd0, resp_w_o}, {63'd0, w});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({nm, "_hold"}, {resp_data_o[61:0], resp_v_o, cmd_ready_o}, {exp_data[61:0], 1'b1, 1'b0});
      end
      resp_yumi = 1'b1;
      @(negedge clk);
      resp_yumi = 1'b0;
      check({nm, "_after_yumi"}, {62'd0, resp_v_o, cmd_ready_o}, 64'd1);
   endtask

   typedef struct {
      logic        w;
      logic [39:0] off;
      logic [1:0]  size;
      logic [63:0] data;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [63:0] rd;
      logic        er;

      vecs[0]  = '{1'b1, 40'h08, 2'd3, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0};
      vecs[1]  = '{1'b0, 40'h08, 2'd3, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0};
      vecs[2]  = '{1'b1, 40'h13, 2'd0, 64'h0000_0000_0000_00AA, 64'd0, 1'b0};
      vecs[3]  = '{1'b0, 40'h10, 2'd2, 64'd0, 64'h0000_0000_AA00_0000, 1'b0};
      vecs[4]  = '{1'b0, 40'h40, 2'd3, 64'd0, 64'd0, ERR_EN};
      vecs[5]  = '{1'b1, 40'h01, 2'd1, 64'h0000_0000_0000_1234, 64'd0, ERR_EN};
      vecs[6]  = '{1'b0, 40'h00, 2'd3, 64'd0, ERR_EN ? 64'd0 : 64'h0000_0000_0000_1234, 1'b0};
      vecs[7]  = '{1'b0, 40'h09, 2'd0, 64'd0, 64'h0000_0000_0000_0045, 1'b0};
      vecs[8]  = '{1'b0, 40'h0E, 2'd1, 64'd0, 64'h0000_0000_0000_DEAD, 1'b0};
      vecs[9]  = '{1'b1, 40'h0C, 2'd2, 64'h0000_0000_CAFE_F00D, 64'd0, 1'b0};
      vecs[10] = '{1'b0, 40'h08, 2'd3, 64'd0, 64'hCAFE_F00D_0123_4567, 1'b0};

      clear_model();

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_outputs", {resp_data_o[59:0], resp_err_o, resp_w_o, resp_v_o, cmd_ready_o}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {62'd0, resp_v_o, cmd_ready_o}, 64'd1);

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         model_access(vecs[i].w, BASE + vecs[i].off, vecs[i].size, vecs[i].data, rd, er);
         run_cmd($sformatf("vec%0d", i), vecs[i].w, BASE + vecs[i].off, vecs[i].size,
                 vecs[i].data, 0, vecs[i].exp_data, vecs[i].exp_err);
      end

      // Long hold with a second command waiting behind it.
      cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = BASE + 40'h08; cmd_size = 2'd3;
      @(negedge clk);
      check("hold_first_resp", resp_data_o, 64'hCAFE_F00D_0123_4567);
      cmd_addr = BASE + 40'h10; cmd_size = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_stable", {resp_data_o[61:0], resp_v_o, cmd_ready_o},
               {64'hCAFE_F00D_0123_4567 << 2} | 64'd2);
      end
      resp_yumi = 1'b1;
      @(negedge clk);
      resp_yumi = 1'b0;
      check("hold_no_early_accept", {62'd0, resp_v_o, cmd_ready_o}, 64'd1);
      @(negedge clk);
      cmd_v = 1'b0;
      check("hold_second_resp", {resp_data_o[62:0], resp_v_o}, {63'hAA00_0000, 1'b1});
      resp_yumi = 1'b1;
      @(negedge clk);
      resp_yumi = 1'b0;

      // Randomized commands against the model.
      for (int i = 0; i < 300; i++) begin
         logic        w;
         logic [1:0]  sz;
         logic [39:0] a;
         logic [63:0] d;
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = BASE - 40'd16 + 40'($urandom_range(0, 8*REG_ELS + 31));
         d  = {$urandom, $urandom};
         model_access(w, a, sz, d, rd, er);
         run_cmd("rand", w, a, sz, d, $urandom_range(0, 2), rd, er);
      end

      // Reset while a response is pending.
      model_access(1'b1, BASE, 2'd3, 64'h1111_2222_3333_4444, rd, er);
      run_cmd("pre_reset_store", 1'b1, BASE, 2'd3, 64'h1111_2222_3333_4444, 0, 64'd0, 1'b0);
      cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = BASE; cmd_size = 2'd3;
      @(negedge clk);
      cmd_v = 1'b0;
      check("pre_reset_resp", {resp_data_o[62:0], resp_v_o}, {63'h1111_2222_3333_4444 << 0, 1'b1} & {64'hFFFF_FFFF_FFFF_FFFF});
      reset_n = 1'b0;
      #1;
      check("reset_kills_resp", {62'd0, resp_v_o, cmd_ready_o}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      clear_model();
      @(negedge clk);
      check("ready_after_mid_reset", {62'd0, resp_v_o, cmd_ready_o}, 64'd1);
      run_cmd("reg0_cleared", 1'b0, BASE, 2'd3, 64'd0, 0, 64'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
